// File: rtl/seq_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Start/done handshake, saturating overflow and a significant-digit count for autoranging.
module seq_bin2bcd #(
  parameter int unsigned BIN_W  = 32,
  parameter int unsigned DIGITS = 10,
  parameter int unsigned CNT_W  = $clog2(BIN_W + 1),
  parameter int unsigned SIG_W  = $clog2(DIGITS + 1)
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [SIG_W-1:0]      sig_digits
);

  localparam int unsigned AccW = 4 * DIGITS;

  typedef enum logic [1:0] {StIdle, StShift, StFinish} state_e;

  state_e             state_q;
  logic [BIN_W-1:0]   sh_q, sh_d;
  logic [AccW-1:0]    acc_q, acc_d, acc_corr;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q, done_q, overflow_q;
  logic [AccW-1:0]    bcd_q, bcd_fin;
  logic [SIG_W-1:0]   sig_q, sig_d, sig_fin;

  // Datapath for one shift step; the final-step values feed the output registers directly.
  always_comb begin
    acc_corr = acc_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_corr[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    acc_d = {acc_corr[AccW-2:0], sh_q[BIN_W-1]};
    sh_d  = {sh_q[BIN_W-2:0], 1'b0};
    ovf_d = ovf_q | acc_corr[AccW-1];

    sig_d = SIG_W'(1);
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc_d[4*i +: 4] != 4'd0) begin
        sig_d = SIG_W'(i + 1);
      end
    end

    if (ovf_d) begin
      bcd_fin = {DIGITS{4'h9}};
      sig_fin = SIG_W'(DIGITS);
    end else begin
      bcd_fin = acc_d;
      sig_fin = sig_d;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sh_q       <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      sig_q      <= SIG_W'(1);
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            sh_q    <= bin;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= CNT_W'(BIN_W);
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          sh_q  <= sh_d;
          acc_q <= acc_d;
          ovf_q <= ovf_d;
          cnt_q <= cnt_q - CNT_W'(1);
          // Outputs are registered on entry to FINISH so they are valid alongside done.
          if (cnt_q == CNT_W'(1)) begin
            state_q    <= StFinish;
            done_q     <= 1'b1;
            bcd_q      <= bcd_fin;
            overflow_q <= ovf_d;
            sig_q      <= sig_fin;
          end
        end
        StFinish: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign bcd        = bcd_q;
  assign overflow   = overflow_q;
  assign sig_digits = sig_q;

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Self-checking bench for seq_bin2bcd: 32-bit/10-digit and 20-bit/6-digit instances.
module tb_seq_bin2bcd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, start_b;
  logic [31:0] bin_a;
  logic [19:0] bin_b;
  logic        busy_a, done_a, ovf_a;
  logic        busy_b, done_b, ovf_b;
  logic [39:0] bcd_a;
  logic [23:0] bcd_b;
  logic [3:0]  sig_a;
  logic [2:0]  sig_b;

  int checks = 0;
  int errors = 0;

  seq_bin2bcd #(.BIN_W(32), .DIGITS(10)) u_dut_a (
    .sys_clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a), .sig_digits(sig_a)
  );

  seq_bin2bcd #(.BIN_W(20), .DIGITS(6)) u_dut_b (
    .sys_clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b), .sig_digits(sig_b)
  );

  typedef struct {
    logic [31:0] bin;
    logic [39:0] bcd;
    logic        ovf;
    logic [3:0]  sig;
  } vec_a_t;

  typedef struct {
    logic [19:0] bin;
    logic [23:0] bcd;
    logic        ovf;
    logic [2:0]  sig;
  } vec_b_t;

  vec_a_t va[9];
  vec_b_t vb[6];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic conv_a(input logic [31:0] b, output logic [39:0] r_bcd, output logic r_ovf,
                        output logic [3:0] r_sig, output int lat, output bit busy_ok);
    busy_ok = 1'b1;
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = b;
    @(posedge clk); #1;
    start_a = 1'b0;
    bin_a   = $urandom;
    lat = 1;
    if (busy_a !== 1'b1) busy_ok = 1'b0;
    while (done_a !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (busy_a !== 1'b1) busy_ok = 1'b0;
    end
    r_bcd = bcd_a;
    r_ovf = ovf_a;
    r_sig = sig_a;
  endtask

  task automatic conv_b(input logic [19:0] b, output logic [23:0] r_bcd, output logic r_ovf,
                        output logic [2:0] r_sig, output int lat, output bit busy_ok);
    busy_ok = 1'b1;
    @(negedge clk);
    start_b = 1'b1;
    bin_b   = b;
    @(posedge clk); #1;
    start_b = 1'b0;
    bin_b   = 20'($urandom);
    lat = 1;
    if (busy_b !== 1'b1) busy_ok = 1'b0;
    while (done_b !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (busy_b !== 1'b1) busy_ok = 1'b0;
    end
    r_bcd = bcd_b;
    r_ovf = ovf_b;
    r_sig = sig_b;
  endtask

  initial begin
    logic [39:0] ra_bcd, last_bcd;
    logic [23:0] rb_bcd;
    logic        r_ovf;
    logic [3:0]  ra_sig;
    logic [2:0]  rb_sig;
    int          lat, nd, prev, first;
    bit          busy_ok;

    va[0] = '{32'd0,          40'h0000000000, 1'b0, 4'd1};
    va[1] = '{32'd123456789,  40'h0123456789, 1'b0, 4'd9};
    va[2] = '{32'hFFFFFFFF,   40'h4294967295, 1'b0, 4'd10};
    va[3] = '{32'd42,         40'h0000000042, 1'b0, 4'd2};
    va[4] = '{32'd1000000000, 40'h1000000000, 1'b0, 4'd10};
    va[5] = '{32'd999999999,  40'h0999999999, 1'b0, 4'd9};
    va[6] = '{32'd7,          40'h0000000007, 1'b0, 4'd1};
    va[7] = '{32'd100,        40'h0000000100, 1'b0, 4'd3};
    va[8] = '{32'd65535,      40'h0000065535, 1'b0, 4'd5};

    vb[0] = '{20'd999999,  24'h999999, 1'b0, 3'd6};
    vb[1] = '{20'd1000000, 24'h999999, 1'b1, 3'd6};
    vb[2] = '{20'hFFFFF,   24'h999999, 1'b1, 3'd6};
    vb[3] = '{20'd5,       24'h000005, 1'b0, 3'd1};
    vb[4] = '{20'd100000,  24'h100000, 1'b0, 3'd6};
    vb[5] = '{20'd0,       24'h000000, 1'b0, 3'd1};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; bin_a = '0; bin_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy_a", 64'(busy_a), 64'd0);
    chk("reset_done_a", 64'(done_a), 64'd0);
    chk("reset_bcd_a", 64'(bcd_a), 64'd0);
    chk("reset_ovf_a", 64'(ovf_a), 64'd0);
    chk("reset_sig_a", 64'(sig_a), 64'd1);
    chk("reset_sig_b", 64'(sig_b), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      conv_a(va[i].bin, ra_bcd, r_ovf, ra_sig, lat, busy_ok);
      chk($sformatf("a%0d_latency", i), 64'(lat), 64'd33);
      chk($sformatf("a%0d_bcd", i), 64'(ra_bcd), 64'(va[i].bcd));
      chk($sformatf("a%0d_ovf", i), 64'(r_ovf), 64'(va[i].ovf));
      chk($sformatf("a%0d_sig", i), 64'(ra_sig), 64'(va[i].sig));
      chk($sformatf("a%0d_busy_window", i), 64'(busy_ok), 64'd1);
      @(posedge clk); #1;
      chk($sformatf("a%0d_done_pulse", i), 64'({done_a, busy_a}), 64'd0);
      chk($sformatf("a%0d_hold", i), 64'(bcd_a), 64'(va[i].bcd));
    end

    for (int i = 0; i < 6; i++) begin
      conv_b(vb[i].bin, rb_bcd, r_ovf, rb_sig, lat, busy_ok);
      chk($sformatf("b%0d_latency", i), 64'(lat), 64'd21);
      chk($sformatf("b%0d_bcd", i), 64'(rb_bcd), 64'(vb[i].bcd));
      chk($sformatf("b%0d_ovf", i), 64'(r_ovf), 64'(vb[i].ovf));
      chk($sformatf("b%0d_sig", i), 64'(rb_sig), 64'(vb[i].sig));
      chk($sformatf("b%0d_busy_window", i), 64'(busy_ok), 64'd1);
      @(posedge clk); #1;
      chk($sformatf("b%0d_done_pulse", i), 64'({done_b, busy_b}), 64'd0);
    end

    // A start pulsed mid-conversion must be dropped, not queued.
    @(negedge clk);
    start_a = 1'b1; bin_a = 32'd77;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start_a = 1'b1; bin_a = 32'd5;
    @(posedge clk); #1;
    start_a = 1'b0;
    nd = 0; last_bcd = '0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (done_a) begin nd++; last_bcd = bcd_a; end
    end
    chk("ignore_done_count", 64'(nd), 64'd1);
    chk("ignore_bcd", 64'(last_bcd), 64'h77);
    chk("ignore_sig", 64'(sig_a), 64'd2);

    // Reset in cycle N+10 clears outputs at once and suppresses done.
    @(negedge clk);
    start_a = 1'b1; bin_a = 32'd123;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy_a), 64'd0);
    chk("midrst_bcd", 64'(bcd_a), 64'd0);
    chk("midrst_ovf", 64'(ovf_a), 64'd0);
    chk("midrst_sig", 64'(sig_a), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done_a) nd++;
    end
    chk("midrst_no_done", 64'(nd), 64'd0);
    conv_a(32'd9, ra_bcd, r_ovf, ra_sig, lat, busy_ok);
    chk("postrst_latency", 64'(lat), 64'd33);
    chk("postrst_bcd", 64'(ra_bcd), 64'h9);
    chk("postrst_busy_window", 64'(busy_ok), 64'd1);
    @(posedge clk); #1;

    // Start held high: back-to-back conversions every BIN_W+2 cycles.
    @(negedge clk);
    start_a = 1'b1; bin_a = 32'd42;
    nd = 0; prev = 0; first = 0;
    for (int k = 1; k <= 150; k++) begin
      @(posedge clk); #1;
      if (done_a) begin
        nd++;
        if (prev == 0) first = k;
        else chk("held_interval", 64'(k - prev), 64'd34);
        chk("held_bcd", 64'(bcd_a), 64'h42);
        chk("held_sig", 64'(sig_a), 64'd2);
        prev = k;
      end
    end
    start_a = 1'b0;
    chk("held_first_done", 64'(first), 64'd33);
    chk("held_done_count", 64'(nd), 64'd4);
    repeat (40) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
